// File: rtl/pipe_mux_n_pkg.sv
// Shared constants for the pipelined N:1 select block: skid-buffer state
// encodings, out-of-range counter width and a saturating increment helper.
package cpu_pkg;

    // Width of the out-of-range beat counter.
    localparam int OOB_W = 8;

    // Skid-buffer occupancy states, kept as plain constants so the encoding
    // is fixed and visible on waveforms.
    localparam logic [1:0] ST_EMPTY = 2'd0;  // no beat buffered
    localparam logic [1:0] ST_ONE   = 2'd1;  // head valid
    localparam logic [1:0] ST_FULL  = 2'd2;  // head and skid valid

    // Counter ceiling.
    localparam logic [OOB_W-1:0] OOB_MAX = '1;

    // Increment that sticks at OOB_MAX instead of wrapping.
    function automatic logic [OOB_W-1:0] sat_inc(input logic [OOB_W-1:0] v);
        logic [OOB_W-1:0] r;
        if (v == OOB_MAX) begin
            r = v;
        end else begin
            r = v + OOB_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Bundle of the upstream select/valid/ready channel, the downstream
// valid/ready channel and the out-of-range counter for pipe_mux_n.
interface pipe_mux_n_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) ();
    import cpu_pkg::*;

    logic [N*WIDTH-1:0] in_data;    // packed channels, channel k at [k*WIDTH +: WIDTH]
    logic [SELW-1:0]    in_sel;     // channel select, sampled with in_valid
    logic               in_valid;   // upstream beat present
    logic               in_ready;   // block can take a beat
    logic [WIDTH-1:0]   out_data;   // selected data of head beat
    logic               out_valid;  // head beat present
    logic               out_ready;  // downstream takes head beat
    logic [OOB_W-1:0]   oob_count;  // saturating count of out-of-range beats

    // Side that feeds the block and consumes its output.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, oob_count
    );

    // The block itself.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, oob_count
    );

endinterface

// File: rtl/pipe_mux_n_muxn.sv
// Purely combinational N:1 channel select. A select value with no matching
// channel yields all-zero data.
module muxn #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]    i_sel,
    output logic [WIDTH-1:0]   o_data
);

    // One masked term per channel; at most one is non-zero.
    logic [WIDTH-1:0] w_term [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_term
            assign w_term[gi] = (i_sel == SELW'(gi)) ? i_data[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    // OR the masked terms together; an out-of-range select matches none.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N; k++) begin
            o_data = o_data | w_term[k];
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// Pipelined N:1 channel select with a two-entry skid buffer (head + skid).
// in_ready comes straight from a flop so the upstream ready path is not
// combinationally tied to out_ready. Out-of-range selects store zero data
// and bump a saturating counter.
module pipe_mux_n
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic         clk,
    input  logic         rst,
    pipe_mux_n_if.slave  bus
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic [OOB_W-1:0] r_oob_count;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_oob;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_drain;

    // Channel select for the incoming beat.
    muxn #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_muxn (
        .i_data (bus.in_data),
        .i_sel  (bus.in_sel),
        .o_data (w_sel_data)
    );

    // Out-of-range detect; with a power-of-two N every select code names
    // a real channel, so the flag is tied off.
    generate
        if ((N & (N - 1)) == 0) begin : g_oob_none
            assign w_oob = 1'b0;
        end else begin : g_oob_cmp
            assign w_oob = (32'(bus.in_sel) >= 32'(N));
        end
    endgenerate

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_drain     = w_out_valid && bus.out_ready;

    // Occupancy transitions of the skid buffer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_state_next = ST_FULL;
                end else if (!w_accept && w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_state_next = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State register and registered in_ready, which follows the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    // Head/skid data movement: head always holds the oldest beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head <= w_sel_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_head <= w_sel_data;
                    end else if (w_accept) begin
                        r_skid <= w_sel_data;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        r_head <= r_skid;
                    end
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
        end
    end

    // Saturating count of accepted beats that selected no channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oob_count <= '0;
        end else if (w_accept && w_oob) begin
            r_oob_count <= sat_inc(r_oob_count);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_head;
    assign bus.oob_count = r_oob_count;

endmodule

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 Parameter WIDTH, default 32, bits per data channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default 2, select width; SHALL equal clog2(N).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SELW  channel select, sampled with in_valid.
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_ready  output  1  block can accept a beat; driven directly from a flop.
REQ-010 out_data  output  WIDTH  selected data of head beat.
REQ-011 out_valid  output  1  head beat present.
REQ-012 out_ready  input  1  downstream accepts head beat.
REQ-013 oob_count  output  8  saturating count of accepted beats with in_sel >= N.

Function
REQ-014 A beat SHALL be accepted when in_valid && in_ready are high on a rising edge.
REQ-015 An accepted beat SHALL store in_data[in_sel] when in_sel < N, and all-zero data otherwise.
REQ-016 Buffering SHALL be a 2-entry skid: a main register (head) and a skid register.
REQ-017 FSM states: EMPTY (0 entries), ONE (head valid), FULL (head and skid valid).
REQ-018 EMPTY: accept -> ONE, head loaded; no accept -> EMPTY.
REQ-019 ONE: accept without drain -> FULL, skid loaded; drain without accept -> EMPTY; accept with drain -> ONE, head loaded with the new beat; neither -> ONE.
REQ-020 FULL: drain -> ONE, head loaded from skid; no drain -> FULL with all data held.
REQ-021 Drain means out_valid && out_ready high on a rising edge.
REQ-022 in_ready SHALL be high in EMPTY and ONE and low in FULL. It SHALL be registered, so it updates one cycle after the state change.
REQ-023 out_valid SHALL be high in ONE and FULL; out_data SHALL be head data.
REQ-024 Latency SHALL be one cycle: a beat accepted at edge t appears on out_data after edge t when the block was EMPTY.
REQ-025 Beats SHALL leave in acceptance order, with no loss or duplication.
REQ-026 out_data SHALL be stable while out_valid && !out_ready.
REQ-027 in_sel and in_data SHALL be ignored when no accept occurs.
REQ-028 oob_count SHALL increment by 1 per accepted beat with in_sel >= N and SHALL saturate at 255.
REQ-029 When N is a power of two, the oob path SHALL be constant zero and oob_count SHALL stay 0.

Reset
REQ-030 rst high SHALL immediately force state EMPTY, out_valid 0, out_data 0, in_ready 1, oob_count 0, and skid data 0.
REQ-031 Reset mid-transfer SHALL discard all buffered beats; no beat is presented after release until a new accept.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 State encoding constants (EMPTY, ONE, FULL) and the OOB counter width SHALL live in shared package cpu_pkg.
REQ-034 One sub-module, muxn (parametrised WIDTH/N combinational N:1 select, zero on out-of-range), SHALL be instantiated for the select path.
REQ-035 No latches; the select path SHALL be purely combinational and all other state flopped.

Verification
REQ-036 N=4, WIDTH=8, channels {0x11,0x22,0x33,0x44}, sel=2, out_ready=1 -> out_data=0x33, out_valid=1 one cycle after accept.
REQ-037 out_ready=0, two accepts (sel 0 then 3) -> state FULL, in_ready=0 next cycle, out_data=0x11 held. Raise out_ready -> 0x11 then 0x44, in order.
REQ-038 N=3, sel=3 accepted 300 times -> out_data=0 each beat, oob_count=255 (saturated).
REQ-039 Continuous in_valid=1, out_ready=1 for 100 beats -> 100 beats out, throughput 1 per cycle, in_ready never low.
REQ-040 Assert rst asynchronously while FULL -> out_valid=0, in_ready=1, oob_count=0 before the next clock edge; no stale beat after release.
REQ-041 Random in_valid/out_ready at 50% over 10k cycles -> scoreboard order and data match, with no drop or duplicate.
